// File: rtl/synth_sched_pkg.sv
// Shared types and default sizing for the oscillator voice scheduler.
package synth_sched_pkg;

  localparam int NUM_VOICES_DEF  = 8;
  localparam int VIDX_W_DEF      = 3;
  localparam int ACK_TIMEOUT_DEF = 15;
  localparam int WAIT_W          = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    REQ  = 2'd2,
    DONE = 2'd3
  } sched_state_t;

endpackage

// File: rtl/osc_voice_scheduler_tick_detect.sv
// Enable-gated rising-edge detector for the synthesizer update clock; the tick is registered.
module syn_tick_detect (
  input  logic Sys_clk,
  input  logic Syn_rst,
  input  logic Syn_ce,
  input  logic Syn_clk,
  output logic Tick
);

  logic prev_reg;
  logic tick_reg;

  always_ff @(posedge Sys_clk) begin
    if (Syn_rst) begin
      prev_reg <= 1'b0;
      tick_reg <= 1'b0;
    end else if (Syn_ce) begin
      prev_reg <= Syn_clk;
      tick_reg <= Syn_clk & ~prev_reg;
    end
  end

  assign Tick = tick_reg;

endmodule

// File: rtl/osc_voice_scheduler.sv
// Sweeps the enabled voices through the shared update datapath once per Syn_clk rise.
// Optional ack timeout is enabled by defining SCHED_ACK_TIMEOUT_EN.
module osc_voice_scheduler
  import synth_sched_pkg::*;
#(
  parameter int NUM_VOICES  = NUM_VOICES_DEF,
  parameter int VIDX_W      = VIDX_W_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                  Sys_clk,
  input  logic                  Syn_rst,
  input  logic                  Syn_ce,
  input  logic                  Syn_clk,
  input  logic [NUM_VOICES-1:0] Voice_en,
  output logic                  Upd_req,
  output logic [VIDX_W-1:0]     Upd_voice,
  input  logic                  Upd_ack,
  output logic                  Sweep_done,
  output logic                  Busy,
  output logic                  Overrun,
  input  logic                  Ovr_clr,
  output logic                  Ack_err
);

  localparam logic [VIDX_W-1:0] LAST_IDX = VIDX_W'(NUM_VOICES - 1);
  localparam logic [VIDX_W-1:0] IDX_ONE  = VIDX_W'(1);

  sched_state_t          state_reg, state_next;
  logic [VIDX_W-1:0]     idx_reg, idx_next;
  logic [NUM_VOICES-1:0] mask_reg, mask_next;
  logic                  req_reg, req_next;
  logic [VIDX_W-1:0]     voice_reg, voice_next;
  logic                  done_reg, done_next;
  logic                  busy_reg, busy_next;
  logic                  overrun_reg, overrun_next;
  logic                  advance;
  logic                  tick;

`ifdef SCHED_ACK_TIMEOUT_EN
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(ACK_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic              ack_err_reg, ack_err_next;
`else
  logic unused_timeout;
  assign unused_timeout = (ACK_TIMEOUT != 0);
`endif

  syn_tick_detect u_tick_detect (
    .Sys_clk (Sys_clk),
    .Syn_rst (Syn_rst),
    .Syn_ce  (Syn_ce),
    .Syn_clk (Syn_clk),
    .Tick    (tick)
  );

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    mask_next    = mask_reg;
    req_next     = req_reg;
    voice_next   = voice_reg;
    done_next    = 1'b0;
    overrun_next = overrun_reg;
    advance      = 1'b0;
`ifdef SCHED_ACK_TIMEOUT_EN
    wait_next    = wait_reg;
    ack_err_next = ack_err_reg;
    if (Ovr_clr) ack_err_next = 1'b0;
`endif
    // Clear first so a coincident set wins.
    if (Ovr_clr) overrun_next = 1'b0;
    if (tick && state_reg != IDLE) overrun_next = 1'b1;

    case (state_reg)
      IDLE: begin
        if (tick) begin
          mask_next  = Voice_en;
          idx_next   = '0;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (mask_reg[idx_reg]) begin
          state_next = REQ;
          req_next   = 1'b1;
          voice_next = idx_reg;
`ifdef SCHED_ACK_TIMEOUT_EN
          wait_next  = '0;
`endif
        end else if (idx_reg == LAST_IDX) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          idx_next = idx_reg + IDX_ONE;
        end
      end
      REQ: begin
        advance = Upd_ack;
`ifdef SCHED_ACK_TIMEOUT_EN
        if (!Upd_ack) begin
          if (wait_reg == WAIT_LIMIT) begin
            advance      = 1'b1;
            ack_err_next = 1'b1;
          end else begin
            wait_next = wait_reg + WAIT_ONE;
          end
        end
`endif
        if (advance) begin
          req_next = 1'b0;
          if (idx_reg == LAST_IDX) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            idx_next   = idx_reg + IDX_ONE;
            state_next = SCAN;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge Sys_clk) begin
    if (Syn_rst) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      mask_reg    <= '0;
      req_reg     <= 1'b0;
      voice_reg   <= '0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      overrun_reg <= 1'b0;
`ifdef SCHED_ACK_TIMEOUT_EN
      wait_reg    <= '0;
      ack_err_reg <= 1'b0;
`endif
    end else if (Syn_ce) begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      mask_reg    <= mask_next;
      req_reg     <= req_next;
      voice_reg   <= voice_next;
      done_reg    <= done_next;
      busy_reg    <= busy_next;
      overrun_reg <= overrun_next;
`ifdef SCHED_ACK_TIMEOUT_EN
      wait_reg    <= wait_next;
      ack_err_reg <= ack_err_next;
`endif
    end
  end

  assign Upd_req    = req_reg;
  assign Upd_voice  = voice_reg;
  assign Sweep_done = done_reg;
  assign Busy       = busy_reg;
  assign Overrun    = overrun_reg;
`ifdef SCHED_ACK_TIMEOUT_EN
  assign Ack_err    = ack_err_reg;
`else
  assign Ack_err    = 1'b0;
`endif

endmodule

// File: tb/tb_osc_voice_scheduler.sv
// Scoreboard bench for osc_voice_scheduler: stimulus queues expected requests, a monitor checks them.
module tb_osc_voice_scheduler;

  logic       Sys_clk = 1'b0;
  logic       Syn_rst = 1'b1;
  logic       Syn_ce = 1'b1;
  logic       Syn_clk = 1'b0;
  logic [7:0] Voice_en = 8'h00;
  logic       Upd_req;
  logic [2:0] Upd_voice;
  logic       Upd_ack = 1'b0;
  logic       Sweep_done;
  logic       Busy;
  logic       Overrun;
  logic       Ovr_clr = 1'b0;
  logic       Ack_err;

  typedef struct {
    int voice;   // -1 marks a Sweep_done pulse
    int len;     // request length in cycles, 0 = not checked
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ack_mode = 0;   // 0 tied high, 1 ack after 3 wait cycles, 2 never

  osc_voice_scheduler dut (
    .Sys_clk    (Sys_clk),
    .Syn_rst    (Syn_rst),
    .Syn_ce     (Syn_ce),
    .Syn_clk    (Syn_clk),
    .Voice_en   (Voice_en),
    .Upd_req    (Upd_req),
    .Upd_voice  (Upd_voice),
    .Upd_ack    (Upd_ack),
    .Sweep_done (Sweep_done),
    .Busy       (Busy),
    .Overrun    (Overrun),
    .Ovr_clr    (Ovr_clr),
    .Ack_err    (Ack_err)
  );

  always #5 Sys_clk = ~Sys_clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Sys_clk);
  endtask

  task automatic push(input int voice, input int len);
    exp_t e;
    e.voice = voice;
    e.len   = len;
    exp_q.push_back(e);
  endtask

  // Raise Syn_clk for two cycles; returns just after edge E+1, where E sampled the rise.
  task automatic fire();
    Syn_clk = 1'b1;
    cyc(2);
    Syn_clk = 1'b0;
  endtask

  // Datapath model driving Upd_ack.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge Sys_clk);
      if (Upd_req) cnt++;
      else cnt = 0;
      case (ack_mode)
        0:       Upd_ack = 1'b1;
        1:       Upd_ack = (cnt >= 4);
        default: Upd_ack = 1'b0;
      endcase
    end
  end

  // Monitor: a request is popped when it ends, a sweep marker when Sweep_done rises.
  initial begin
    logic req_d = 1'b0;
    logic done_d = 1'b0;
    int   cur_v = 0;
    int   cur_len = 0;
    exp_t e;
    forever begin
      @(negedge Sys_clk);
      if (Upd_req && !req_d) begin
        cur_v   = int'(Upd_voice);
        cur_len = 0;
      end
      if (Upd_req) begin
        cur_len++;
        if (req_d) check("voice_stable", int'(Upd_voice), cur_v);
      end
      if (!Upd_req && req_d) begin
        $display("tx voice %0d held %0d cycles", cur_v, cur_len);
        if (exp_q.size() == 0) begin
          check("unexpected_request", cur_v, -2);
        end else begin
          e = exp_q.pop_front();
          check("req_voice", cur_v, e.voice);
          if (e.len != 0) check("req_len", cur_len, e.len);
        end
      end
      if (Sweep_done && !done_d) begin
        $display("tx sweep_done");
        if (exp_q.size() == 0) begin
          check("unexpected_sweep_done", -1, -2);
        end else begin
          e = exp_q.pop_front();
          check("sweep_done_order", -1, e.voice);
        end
      end
      req_d  = Upd_req;
      done_d = Sweep_done;
    end
  end

  initial begin
    // Reset state
    cyc(3);
    check("rst_upd_req", int'(Upd_req), 0);
    check("rst_upd_voice", int'(Upd_voice), 0);
    check("rst_sweep_done", int'(Sweep_done), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_overrun", int'(Overrun), 0);
    check("rst_ack_err", int'(Ack_err), 0);
    Syn_rst = 1'b0;
    cyc(3);

    // Full mask, ack tied high: request at E+2, Sweep_done at E+17
    Voice_en = 8'hFF;
    ack_mode = 0;
    for (int v = 0; v < 8; v++) push(v, 1);
    push(-1, 0);
    fire();
    check("t1_req_low_e1", int'(Upd_req), 0);
    cyc(1);
    check("t1_req_high_e2", int'(Upd_req), 1);
    check("t1_voice0", int'(Upd_voice), 0);
    cyc(14);
    check("t1_done_e16", int'(Sweep_done), 0);
    cyc(1);
    check("t1_done_e17", int'(Sweep_done), 1);
    check("t1_busy_e17", int'(Busy), 1);
    cyc(1);
    check("t1_done_e18", int'(Sweep_done), 0);
    check("t1_busy_e18", int'(Busy), 0);
    cyc(2);
    check("t1_queue_empty", exp_q.size(), 0);

    // Empty mask: Sweep_done at E+9, no requests
    Voice_en = 8'h00;
    push(-1, 0);
    fire();
    cyc(7);
    check("t0_done_e8", int'(Sweep_done), 0);
    cyc(1);
    check("t0_done_e9", int'(Sweep_done), 1);
    cyc(3);
    check("t0_queue_empty", exp_q.size(), 0);

    // Sparse mask 0x81 with delayed ack: each request held 4 cycles
    Voice_en = 8'h81;
    ack_mode = 1;
    push(0, 4);
    push(7, 4);
    push(-1, 0);
    fire();
    cyc(40);
    check("t2_queue_empty", exp_q.size(), 0);
    ack_mode = 0;
    cyc(2);

    // Overrun: second tick while stuck in REQ
    Voice_en = 8'h01;
    ack_mode = 2;
    push(0, 0);
    push(-1, 0);
    fire();
    cyc(96);
    check("t3_overrun_before", int'(Overrun), 0);
    check("t3_req_waiting", int'(Upd_req), 1);
    Syn_clk = 1'b1;
    cyc(2);
    Syn_clk = 1'b0;
    check("t3_overrun_set", int'(Overrun), 1);
    check("t3_req_unaffected", int'(Upd_req), 1);
    Ovr_clr = 1'b1;
    cyc(1);
    Ovr_clr = 1'b0;
    check("t3_overrun_cleared", int'(Overrun), 0);
    Syn_clk = 1'b1;
    cyc(1);
    Ovr_clr = 1'b1;
    cyc(1);
    Ovr_clr = 1'b0;
    Syn_clk = 1'b0;
    check("t3_set_wins", int'(Overrun), 1);
    ack_mode = 0;
    cyc(10);
    check("t3_queue_empty", exp_q.size(), 0);
    Ovr_clr = 1'b1;
    cyc(1);
    Ovr_clr = 1'b0;
    check("t3_overrun_final", int'(Overrun), 0);
    check("t3_busy_final", int'(Busy), 0);

    // Reset with Syn_ce low while in REQ for voice 2
    Voice_en = 8'h04;
    ack_mode = 2;
    push(2, 0);
    fire();
    cyc(6);
    check("t4_req_before_rst", int'(Upd_req), 1);
    check("t4_voice2", int'(Upd_voice), 2);
    Syn_ce  = 1'b0;
    Syn_rst = 1'b1;
    cyc(1);
    check("t4_req_after_rst", int'(Upd_req), 0);
    check("t4_busy_after_rst", int'(Busy), 0);
    check("t4_done_after_rst", int'(Sweep_done), 0);
    Syn_rst  = 1'b0;
    Syn_ce   = 1'b1;
    ack_mode = 0;
    cyc(20);
    check("t4_busy_idle", int'(Busy), 0);
    check("t4_queue_empty", exp_q.size(), 0);

    // Syn_ce low for 10 cycles while voice 1 is requested
    Voice_en = 8'hFF;
    push(0, 1);
    push(1, 11);
    for (int v = 2; v < 8; v++) push(v, 1);
    push(-1, 0);
    fire();
    cyc(3);
    check("t5_req_e4", int'(Upd_req), 1);
    check("t5_voice_e4", int'(Upd_voice), 1);
    Syn_ce = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("t5_frozen_req", int'(Upd_req), 1);
      check("t5_frozen_voice", int'(Upd_voice), 1);
      check("t5_frozen_busy", int'(Busy), 1);
    end
    Syn_ce = 1'b1;
    cyc(12);
    check("t5_done_e16", int'(Sweep_done), 0);
    cyc(1);
    check("t5_done_e17", int'(Sweep_done), 1);
    cyc(3);
    check("t5_queue_empty", exp_q.size(), 0);

    // Voice_en cleared mid-sweep: latched mask still serves all voices
    Voice_en = 8'hFF;
    for (int v = 0; v < 8; v++) push(v, 1);
    push(-1, 0);
    fire();
    cyc(3);
    Voice_en = 8'h00;
    cyc(20);
    check("t6_queue_empty", exp_q.size(), 0);
    check("t6_busy_idle", int'(Busy), 0);

`ifdef SCHED_ACK_TIMEOUT_EN
    // Ack never given: each request abandoned after 15 cycles
    Voice_en = 8'h03;
    ack_mode = 2;
    push(0, 15);
    push(1, 15);
    push(-1, 0);
    fire();
    cyc(50);
    check("t7_ack_err", int'(Ack_err), 1);
    check("t7_queue_empty", exp_q.size(), 0);
    Ovr_clr = 1'b1;
    cyc(1);
    Ovr_clr = 1'b0;
    check("t7_ack_err_clr", int'(Ack_err), 0);
    ack_mode = 0;
`else
    check("ack_err_tied_low", int'(Ack_err), 0);
`endif

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/osc_voice_scheduler.md
Name: osc_voice_scheduler

Overview:
- Time-multiplexes the shared oscillator update datapath across NUM_VOICES voices.
- Each rising edge of the synthesizer update clock Syn_clk (1 MHz, 100 Sys_clk cycles per period) starts one sweep.
- A sweep issues one req/ack update transaction per enabled voice, in ascending index order.
- Sits between Synth_clk and the phase-accumulator/wave datapath.

Parameters:
- NUM_VOICES, 8, number of voices; 2..16.
- VIDX_W, 3, voice index width; must equal clog2(NUM_VOICES).
- ACK_TIMEOUT, 15, max Sys_clk cycles in REQ waiting for ack (used only with optional feature).

Ports:
- Sys_clk  in  1  system clock, 100 MHz.
- Syn_rst  in  1  synchronous active-high reset.
- Syn_ce  in  1  active-high enable; low freezes all state.
- Syn_clk  in  1  update clock from Synth_clk, synchronous to Sys_clk.
- Voice_en  in  NUM_VOICES  per-voice enable mask.
- Upd_req  out  1  update request to datapath.
- Upd_voice  out  VIDX_W  voice index of current request.
- Upd_ack  in  1  datapath accepts current request.
- Sweep_done  out  1  one-cycle pulse at end of sweep.
- Busy  out  1  high whenever state != IDLE.
- Overrun  out  1  sticky: tick arrived while busy.
- Ovr_clr  in  1  clears Overrun and Ack_err.
- Ack_err  out  1  sticky ack-timeout flag.

Behaviour:
- Control priority: Syn_rst overrides Syn_ce; Syn_ce low holds every register, including the edge-detect register.
- Reset values: state=IDLE, idx=0, Syn_clk_prev=0, Upd_req=0, Upd_voice=0, Sweep_done=0, Busy=0, Overrun=0, Ack_err=0, latched mask=0.
- Tick: tick = Syn_clk & ~Syn_clk_prev. Syn_clk_prev is registered each enabled cycle.
- All outputs are registered.
- IDLE state:
  - On tick: latch Voice_en into mask, idx<=0, go to SCAN.
  - Voice_en changes during a sweep are ignored until the next sweep.
- SCAN state (one cycle per index examined):
  - If mask[idx]: go to REQ, Upd_req<=1, Upd_voice<=idx.
  - Else if idx==NUM_VOICES-1: go to DONE.
  - Else idx<=idx+1.
- REQ state:
  - Upd_req and Upd_voice are held stable until a cycle with Upd_ack=1 is sampled.
  - On ack: Upd_req<=0 on that edge (one transaction per ack). If idx==NUM_VOICES-1 go to DONE, else idx<=idx+1 and go to SCAN.
  - Upd_ack while Upd_req=0 is ignored.
- DONE state: Sweep_done<=1 for exactly one cycle, then IDLE.
- Latency:
  - Upd_req rises 2 edges after the edge that samples tick.
  - All voices enabled with ack tied high: 2 cycles per voice, so Sweep_done pulses 2*NUM_VOICES+1 edges after tick (17 for default).
  - Mask all zero: Sweep_done after NUM_VOICES+1 edges, no requests.
- Overrun:
  - A tick when state != IDLE is dropped and sets Overrun.
  - Overrun set and Ovr_clr in the same cycle: set wins.
  - The sweep in progress continues unaffected.
- Reset mid-transaction: Upd_req drops on the reset edge, no completion pulse, counters and flags cleared.

Optional Feature:
- Macro: SCHED_ACK_TIMEOUT_EN.
- With the macro defined:
  - A 4-bit wait counter is cleared on REQ entry and increments each REQ cycle without ack.
  - When the count reaches ACK_TIMEOUT, the voice is abandoned: Upd_req<=0, Ack_err set (sticky; set wins over Ovr_clr), sweep continues as if acked.
- Without the macro: REQ waits indefinitely, and Ack_err is tied 0.

Decomposition:
- Package synth_sched_pkg holds:
  - State enum {IDLE, SCAN, REQ, DONE}, 2-bit.
  - Default NUM_VOICES, VIDX_W and ACK_TIMEOUT constants.
- One natural sub-module: syn_tick_detect (enable-gated rising-edge detector, synchronous reset, tick output).

Test Plan:
- Default params, Voice_en=0xFF, Upd_ack tied 1, one Syn_clk rise -> Upd_voice sequence 0..7, 8 req/ack pairs, Sweep_done at edge 17, Busy low after.
- Voice_en=0x81, ack delayed 3 cycles -> requests only for voices 0 and 7, each held 4 cycles with Upd_voice stable, then one Sweep_done.
- Upd_ack held 0 and a second Syn_clk rise 100 cycles later -> Overrun=1, second tick dropped. Ovr_clr pulse -> Overrun=0; Ovr_clr coincident with a new overrun -> Overrun stays 1.
- Syn_rst asserted while in REQ with Syn_ce=0 -> next edge Upd_req=0, Busy=0, no Sweep_done pulse. Syn_ce low mid-sweep for 10 cycles -> outputs frozen, sweep resumes exactly.
- SCHED_ACK_TIMEOUT_EN defined, ack never given, Voice_en=0x03 -> each request lasts 15 cycles, Ack_err=1, Sweep_done still issued.
- Voice_en toggled to 0x00 mid-sweep with mask 0xFF latched -> all 8 voices still served.
